truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
//  Synthesizable self-checking stimulus engine for a combinational N-input, 1-output block.
//  - Sweeps every input vector 0..2^N_IN-1.
//  - Samples the block's response after a fixed settle time.
//  - Compares each response against a reference truth table latched at start.
//  - Reports mismatch count, first failing vector and a per-vector mismatch bitmap.
//  Sits between a control/CSR master and the block under check.
// PARAMETERS
//  N_IN    3          number of inputs of checked block; vector width
//  SETTLE  1          cycles vector is held before sampling; legal range >=1
//  CNT_W   N_IN+1     width of error counter; holds 0..2^N_IN
// PORTS
//  clk              in   1          clock, rising edge
//  aresetn          in   1          async active-low reset
//  start_i          in   1          one-cycle start pulse; honoured only in IDLE
//  ref_table_i      in   2**N_IN    bit k = expected response for vector k; latched on accepted start
//  vec_o            out  N_IN       vector driven to checked block; MSB = first input (a)
//  rsp_i            in   1          response of checked block
//  busy_o           out  1          high from cycle after accepted start until done
//  done_o           out  1          one-cycle pulse at end of sweep
//  err_cnt_o        out  CNT_W      number of mismatching vectors in last/current run
//  first_err_vld_o  out  1          a mismatch has been recorded in this run
//  first_err_vec_o  out  N_IN       vector of first mismatch; valid when first_err_vld_o=1
//  mismatch_map_o   out  2**N_IN    bit k set if vector k mismatched
// BEHAVIOUR
//  Reset (aresetn=0, async): all outputs 0; FSM=IDLE; internal counters and latched table cleared.
//  FSM states:
//   IDLE   - start_i=1: latch ref_table_i; clear err_cnt, first_err_*, map; vec_o=0; go SETTLE.
//   SETTLE - hold vec_o; settle counter 0..SETTLE-1; at SETTLE-1 go SAMPLE.
//   SAMPLE - compare rsp_i with ref[vec_o]. On mismatch:
//            err_cnt+1; map[vec_o]=1; if first_err_vld_o=0, capture vec_o and set first_err_vld_o.
//            If vec_o = 2^N_IN-1 go DONE; else vec_o+1 and go SETTLE.
//   DONE   - done_o=1 for exactly one cycle; busy_o=0; go IDLE.
//  Timing:
//  - Each vector occupies SETTLE+1 cycles.
//  - busy_o rises the cycle after start_i and stays high for 2^N_IN*(SETTLE+1) cycles;
//    done_o pulses in the cycle after busy_o falls.
//  - N_IN=3, SETTLE=1: 16 busy cycles.
//  Boundary conditions:
//  - start_i while busy_o=1 or in DONE: ignored; ref_table_i changes mid-run have no effect.
//  - Result outputs (err_cnt_o, first_err_*, mismatch_map_o) hold until next accepted start;
//    vec_o holds its last value in IDLE.
//  - err_cnt_o saturates naturally at 2^N_IN; no wrap, since CNT_W=N_IN+1.
//  - vec_o does not wrap: the sweep ends at the last vector.
//  - Reset mid-run aborts immediately to reset values; no done_o is generated.
//  - rsp_i is sampled only in SAMPLE; X/changes in other states are ignored.
// CONFIGURATION
//  TT_CHECKER_STOP_ON_ERR_EN defined:
//  - The first mismatch ends the sweep: SAMPLE goes to DONE after recording it.
//  - err_cnt_o=1 and mismatch_map_o has a single bit set.
//  TT_CHECKER_STOP_ON_ERR_EN undefined:
//  - Full sweep always completes, regardless of mismatches.
// TESTING
//  (Default params N_IN=3, SETTLE=1; bench models the checked block combinationally from vec_o.)
//  1. Reset: assert aresetn=0 mid-idle
//     -> all outputs 0; no done_o while low.
//  2. Model = ref, ref_table_i=8'h36, start
//     -> busy_o 16 cycles; vec_o 0..7 each 2 cycles; done_o pulse;
//        err_cnt_o=0, map=8'h00, first_err_vld_o=0.
//  3. Model table 8'h7E, ref 8'h36, start
//     -> err_cnt_o=2, mismatch_map_o=8'h48, first_err_vec_o=3'd3, first_err_vld_o=1.
//  4. start_i pulses at busy cycles 3 and 10, plus ref_table_i changes mid-run
//     -> single sweep, results identical to scenario 3.
//  5. aresetn low during vector 4 of scenario 3
//     -> outputs reset, no done_o; after release, new start gives scenario 3 result.
//  6. With TT_CHECKER_STOP_ON_ERR_EN, scenario 3
//     -> done_o after vector 3 sample (8 busy cycles); err_cnt_o=1, map=8'h08.

Source files
------------

// File: rtl/truth_table_checker.sv
// Sweeps all 2^N_IN vectors into a combinational block and checks each response against a latched truth table.
// Each vector takes SETTLE+1 cycles; done_o pulses one cycle after busy_o falls. Starts during a run are ignored.
// TT_CHECKER_STOP_ON_ERR_EN: when defined, the first mismatch ends the sweep.
module truth_table_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   ref_table_i,
  output logic [N_IN-1:0]      vec_o,
  input  logic                 rsp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 first_err_vld_o,
  output logic [N_IN-1:0]      first_err_vec_o,
  output logic [2**N_IN-1:0]   mismatch_map_o
);

  localparam int                SC_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]   LAST_VEC = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2**N_IN-1:0]  r_ref;
  logic [N_IN-1:0]     r_vec;
  logic [SC_W-1:0]     r_sc;
  logic [CNT_W-1:0]    r_err_cnt;
  logic                r_first_vld;
  logic [N_IN-1:0]     r_first_vec;
  logic [2**N_IN-1:0]  r_map;

  logic w_start_acc;
  logic w_mismatch;
  logic w_stop;

  assign w_start_acc = (r_state == S_IDLE) && start_i;
  assign w_mismatch  = (r_state == S_SAMPLE) && (rsp_i != r_ref[r_vec]);

`ifdef TT_CHECKER_STOP_ON_ERR_EN
  assign w_stop = (r_vec == LAST_VEC) || w_mismatch;
`else
  assign w_stop = (r_vec == LAST_VEC);
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_next = S_SETTLE;
      S_SETTLE: if (r_sc == SC_LAST) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_stop ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_ref       <= '0;
      r_vec       <= '0;
      r_sc        <= '0;
      r_err_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_vec <= '0;
      r_map       <= '0;
    end else begin
      if (w_start_acc) begin
        r_ref       <= ref_table_i;
        r_vec       <= '0;
        r_sc        <= '0;
        r_err_cnt   <= '0;
        r_first_vld <= 1'b0;
        r_first_vec <= '0;
        r_map       <= '0;
      end
      if (r_state == S_SETTLE) begin
        r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + 1'b1;
      end
      if (r_state == S_SAMPLE) begin
        if (w_mismatch) begin
          r_err_cnt    <= r_err_cnt + 1'b1;
          r_map[r_vec] <= 1'b1;
          if (!r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_vec <= r_vec;
          end
        end
        // vec_o stays on the last checked vector once the sweep ends
        if (!w_stop) begin
          r_vec <= r_vec + 1'b1;
        end
      end
    end
  end

  assign vec_o           = r_vec;
  assign busy_o          = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done_o          = (r_state == S_DONE);
  assign err_cnt_o       = r_err_cnt;
  assign first_err_vld_o = r_first_vld;
  assign first_err_vec_o = r_first_vec;
  assign mismatch_map_o  = r_map;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: the checked block is a lookup into model_tbl driven from vec_o.
// Expected results come from the XOR of model and reference tables.
module tb_truth_table_checker;

  localparam int N_IN   = 3;
  localparam int SETTLE = 1;
  localparam int CNT_W  = N_IN + 1;
  localparam int NV     = 2**N_IN;
  localparam int PER    = SETTLE + 1;
`ifdef TT_CHECKER_STOP_ON_ERR_EN
  localparam int RST_VEC = 2;
`else
  localparam int RST_VEC = 4;
`endif

  logic              clk = 1'b0;
  logic              aresetn = 1'b1;
  logic              start_i = 1'b0;
  logic [NV-1:0]     ref_table_i = '0;
  logic [N_IN-1:0]   vec_o;
  logic              rsp_i;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  err_cnt_o;
  logic              first_err_vld_o;
  logic [N_IN-1:0]   first_err_vec_o;
  logic [NV-1:0]     mismatch_map_o;
  logic [NV-1:0]     model_tbl = '0;

  int n_chk = 0;
  int n_err = 0;

  truth_table_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .start_i         (start_i),
    .ref_table_i     (ref_table_i),
    .vec_o           (vec_o),
    .rsp_i           (rsp_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_vld_o (first_err_vld_o),
    .first_err_vec_o (first_err_vec_o),
    .mismatch_map_o  (mismatch_map_o)
  );

  assign rsp_i = model_tbl[vec_o];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {vec_o, busy_o, done_o, err_cnt_o, first_err_vld_o, first_err_vec_o, mismatch_map_o}, 32'd0);
  endtask

  // disturb: extra start pulses and a reference change while busy
  task automatic run_sweep(input logic [NV-1:0] model, input logic [NV-1:0] reft, input bit disturb);
    logic [NV-1:0] diff, emap;
    int ecnt, efirst, ebusy, nbusy;
    diff   = model ^ reft;
    efirst = -1;
    for (int k = 0; k < NV; k++) if (diff[k] && efirst < 0) efirst = k;
    ecnt  = $countones(diff);
    emap  = diff;
    ebusy = NV * PER;
`ifdef TT_CHECKER_STOP_ON_ERR_EN
    if (efirst >= 0) begin
      ecnt         = 1;
      emap         = '0;
      emap[efirst] = 1'b1;
      ebusy        = (efirst + 1) * PER;
    end
`endif
    model_tbl   = model;
    ref_table_i = reft;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    nbusy = 0;
    while (busy_o === 1'b1 && nbusy < 100) begin
      chk("vec_seq", 32'(vec_o), 32'(nbusy / PER));
      chk("done_while_busy", 32'(done_o), 32'd0);
      nbusy++;
      if (disturb) begin
        start_i = (nbusy == 3 || nbusy == 10);
        if (nbusy == 5) ref_table_i = ~reft;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("busy_cycles", 32'(nbusy), 32'(ebusy));
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("err_cnt", 32'(err_cnt_o), 32'(ecnt));
    chk("mismatch_map", 32'(mismatch_map_o), 32'(emap));
    chk("first_vld", 32'(first_err_vld_o), (efirst >= 0) ? 32'd1 : 32'd0);
    chk("first_vec", 32'(first_err_vec_o), (efirst >= 0) ? 32'(efirst) : 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("idle_not_busy", 32'(busy_o), 32'd0);
    chk("vec_hold", 32'(vec_o), 32'(ebusy / PER - 1));
    chk("err_hold", 32'(err_cnt_o), 32'(ecnt));
  endtask

  task automatic reset_hold(input string tag);
    aresetn = 1'b0;
    #1;
    chk_all_zero(tag);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(done_o), 32'd0);
    end
    aresetn = 1'b1;
    @(negedge clk);
    chk_all_zero({tag, "_after_release"});
  endtask

  initial begin
    int guard;
    logic [NV-1:0] rm, rr;
    #2 aresetn = 1'b0;
    #1 chk_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    run_sweep(8'h36, 8'h36, 1'b0);

    @(negedge clk);
    reset_hold("reset_idle");

    run_sweep(8'h7E, 8'h36, 1'b0);
    run_sweep(8'h7E, 8'h36, 1'b1);

    // reset in the middle of a run
    model_tbl   = 8'h7E;
    ref_table_i = 8'h36;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    guard = 0;
    while (!(vec_o == N_IN'(RST_VEC) && busy_o === 1'b1) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    chk("reach_reset_vec", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
    reset_hold("reset_mid_run");
    run_sweep(8'h7E, 8'h36, 1'b0);

    run_sweep(8'hA5, 8'h5A, 1'b0);
    run_sweep(8'h00, 8'h80, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rm = NV'($urandom_range(0, 255));
      rr = NV'($urandom_range(0, 255));
      run_sweep(rm, rr, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
